// File: rtl/if_buffer_pkg.sv
// Shared constants for the instruction fetch path (fetch buffer, PC stage,
// decode), plus a sizing helper for occupancy counters.
package if_buffer_pkg;

    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] NOP_INST    = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD   = 32'h0;

    // An occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_buffer_fifo.sv
// if_fifo: parameterised synchronous FIFO holding {pc, inst} fetch entries.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_wdata at the tail
//   i_wdata    entry to write
//   i_pop      advance the head (ignored when empty)
//   i_clear    discard everything; wins over push/pop in the same cycle
//   o_count    number of stored entries
//   o_head     entry at the head (meaningful only when o_count != 0)
module if_fifo
    import if_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    input  logic          i_clear,
    output logic [CW-1:0] o_count,
    output logic [W-1:0]  o_head
);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PW-1:0]           r_wr;
    logic [PW-1:0]           r_rd;
    logic [CW-1:0]           r_count;
    logic                    w_pop;

    assign w_pop   = i_pop & (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !rst && !i_clear) r_mem[r_wr] <= i_wdata;
    end

    // Upstream credit accounting must never let a push land on a full FIFO.
    always_ff @(posedge clk) begin
        if (i_push && !rst && !i_clear) assert (r_count < CW'(DEPTH));
    end

endmodule

// File: rtl/if_buffer.sv
// if_buffer: stage-1 instruction fetch buffer. Issues PC reads to a
// synchronous ROM, captures the returned word one cycle later, and queues
// {pc, inst} pairs for decode behind a valid/ready handshake. Credits
// (buffered + in-flight) stall the PC stage so no ROM response is dropped.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pc_i/pc_ce_i fetch address and its valid from the PC stage
//   fetch_stall  PC stage must hold pc_i this cycle
//   rom_ce_o     ROM read enable; rom_addr_o = pc_i
//   rom_inst_i   ROM data, valid the cycle after rom_ce_o
//   flush_i      kill all buffered and in-flight fetches
//   id_valid_o/id_ready_i  decode handshake; id_pc_o/id_inst_o head entry
module if_buffer
    import if_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = INST_ADDR_W,
    parameter int DW    = INST_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_i,
    input  logic          pc_ce_i,
    output logic          fetch_stall,
    output logic          rom_ce_o,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_inst_i,
    input  logic          flush_i,
    output logic          id_valid_o,
    input  logic          id_ready_i,
    output logic [AW-1:0] id_pc_o,
    output logic [DW-1:0] id_inst_o
);

    localparam int CW = cnt_w(DEPTH);

    logic             r_req_valid;
    logic [AW-1:0]    r_req_pc;
    logic [CW-1:0]    w_count;
    logic [AW+DW-1:0] w_head;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;

    // Credits come from registered state only, deliberately ignoring
    // id_ready_i so there is no comb path from decode back to the PC stage.
    assign fetch_stall = ({1'b0, w_count} + {{CW{1'b0}}, r_req_valid}) >= (CW+1)'(DEPTH);

    // Reset also blocks issue so the ROM stays idle while rst is held.
    assign w_issue    = pc_ce_i & ~flush_i & ~rst & ~fetch_stall;
    assign rom_ce_o   = w_issue;
    assign rom_addr_o = pc_i;

    assign w_push  = r_req_valid & ~flush_i;
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & id_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
        end else if (flush_i) begin
            r_req_valid <= 1'b0;
        end else begin
            r_req_valid <= w_issue;
            if (w_issue) r_req_pc <= pc_i;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({r_req_pc, rom_inst_i}),
        .i_pop   (w_pop),
        .i_clear (flush_i),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign id_valid_o = w_valid;
    assign id_pc_o    = w_valid ? w_head[AW+DW-1:DW] : '0;
    assign id_inst_o  = w_valid ? w_head[DW-1:0]     : DW'(NOP_INST);

endmodule

// File: tb/tb_if_buffer.sv
module tb_if_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        pc_ce_i = 1'b0;
    logic        fetch_stall;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i = '0;
    logic        flush_i = 1'b0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int total  = 0;
    int passed = 0;

    if_buffer #(.DEPTH(2), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .pc_ce_i     (pc_ce_i),
        .fetch_stall (fetch_stall),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .rom_inst_i  (rom_inst_i),
        .flush_i     (flush_i),
        .id_valid_o  (id_valid_o),
        .id_ready_i  (id_ready_i),
        .id_pc_o     (id_pc_o),
        .id_inst_o   (id_inst_o)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the read enable.
    always @(posedge clk) if (rom_ce_o) rom_inst_i <= rom_addr_o ^ 32'hA5A5_0000;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drv(input logic r, input logic ce, input logic [31:0] pc,
                       input logic fl, input logic rdy);
        @(negedge clk);
        rst = r; pc_ce_i = ce; pc_i = pc; flush_i = fl; id_ready_i = rdy;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic fe(input string tag, input logic ce, input logic stall);
        chkb({tag, ".rom_ce"}, rom_ce_o, ce);
        chkb({tag, ".stall"}, fetch_stall, stall);
    endtask

    task automatic id(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chkb({tag, ".valid"}, id_valid_o, v);
        chk({tag, ".pc"}, id_pc_o, pc);
        chk({tag, ".inst"}, id_inst_o, inst);
    endtask

    initial begin
        // Reset held 3 cycles with the PC stage requesting.
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 32'h0, 0, 1);
            chkb("rst.rom_ce", rom_ce_o, 1'b0);
            chkb("rst.valid", id_valid_o, 1'b0);
            chk("rst.inst", id_inst_o, 32'h0);
        end

        // Streaming with decode always ready (DEPTH=2 credits pace issue).
        drv(0, 1, 32'h0, 0, 1);  fe("s0", 1, 0); id("s0", 0, 0, 0); chk("s0.addr", rom_addr_o, 32'h0);
        drv(0, 1, 32'h4, 0, 1);  fe("s1", 1, 0); id("s1", 0, 0, 0);
        drv(0, 1, 32'h8, 0, 1);  fe("s2", 0, 1); id("s2", 1, 32'h0, 32'hA5A5_0000);
        drv(0, 1, 32'h8, 0, 1);  fe("s3", 1, 0); id("s3", 1, 32'h4, 32'hA5A5_0004);
        drv(0, 1, 32'hC, 0, 1);  fe("s4", 1, 0); id("s4", 0, 0, 0);
        drv(0, 1, 32'h10, 0, 1); fe("s5", 0, 1); id("s5", 1, 32'h8, 32'hA5A5_0008);

        // Mid-stream reset, then back-pressure.
        drv(1, 0, 32'h0, 0, 0);
        drv(0, 1, 32'h0, 0, 0);  fe("b0", 1, 0); id("b0", 0, 0, 0);
        drv(0, 1, 32'h4, 0, 0);  fe("b1", 1, 0);
        drv(0, 1, 32'h8, 0, 0);  fe("b2", 0, 1); id("b2", 1, 32'h0, 32'hA5A5_0000);
        drv(0, 1, 32'h8, 0, 0);  fe("b3", 0, 1); id("b3", 1, 32'h0, 32'hA5A5_0000);
        drv(0, 1, 32'h8, 0, 0);  fe("b4", 0, 1);
        drv(0, 1, 32'h8, 0, 1);  fe("b5", 0, 1); id("b5", 1, 32'h0, 32'hA5A5_0000);
        drv(0, 1, 32'h8, 0, 1);  fe("b6", 1, 0); id("b6", 1, 32'h4, 32'hA5A5_0004);
        drv(0, 1, 32'hC, 0, 1);  fe("b7", 1, 0); id("b7", 0, 0, 0);
        // count=1 with push and pop together: head advances 8 -> C.
        drv(0, 1, 32'h10, 0, 1); fe("b8", 0, 1); id("b8", 1, 32'h8, 32'hA5A5_0008);
        drv(0, 1, 32'h10, 0, 0); fe("b9", 1, 0); id("b9", 1, 32'hC, 32'hA5A5_000C);

        // Flush with one buffered and one in flight, then redirect to 0x100.
        drv(0, 1, 32'h14, 1, 1);  fe("f0", 0, 1); id("f0", 1, 32'hC, 32'hA5A5_000C);
        drv(0, 1, 32'h100, 0, 0); fe("f1", 1, 0); id("f1", 0, 0, 0); chk("f1.addr", rom_addr_o, 32'h100);
        drv(0, 0, 32'h0, 0, 0);   fe("f2", 0, 0); id("f2", 0, 0, 0);
        drv(0, 1, 32'h104, 0, 0); fe("f3", 1, 0); id("f3", 1, 32'h100, 32'hA5A5_0100);
        drv(0, 0, 32'h0, 0, 0);   fe("f4", 0, 1); id("f4", 1, 32'h100, 32'hA5A5_0100);
        // Flush at count=2 coinciding with a pop.
        drv(0, 1, 32'h108, 1, 1); fe("f5", 0, 1); id("f5", 1, 32'h100, 32'hA5A5_0100);
        drv(0, 1, 32'h200, 0, 0); fe("f6", 1, 0); id("f6", 0, 0, 0);
        drv(0, 0, 32'h0, 0, 0);   fe("f7", 0, 0); id("f7", 0, 0, 0);
        drv(0, 1, 32'h204, 0, 0); fe("f8", 1, 0); id("f8", 1, 32'h200, 32'hA5A5_0200);
        // Flush coinciding with push and pop.
        drv(0, 1, 32'h208, 1, 1); fe("f9", 0, 1); id("f9", 1, 32'h200, 32'hA5A5_0200);
        drv(0, 0, 32'h0, 0, 0);   fe("f10", 0, 0); id("f10", 0, 0, 0);
        // Flush beats an otherwise unstalled issue.
        drv(0, 1, 32'h500, 1, 0); fe("f11", 0, 0);
        drv(0, 0, 32'h0, 0, 0);   fe("f12", 0, 0); id("f12", 0, 0, 0);

        // Reset with two entries buffered.
        drv(0, 1, 32'h300, 0, 0); fe("r0", 1, 0);
        drv(0, 1, 32'h304, 0, 0); fe("r1", 1, 0); id("r1", 0, 0, 0);
        drv(0, 1, 32'h308, 0, 0); fe("r2", 0, 1); id("r2", 1, 32'h300, 32'hA5A5_0300);
        drv(1, 1, 32'h308, 0, 0); fe("r3", 0, 1); id("r3", 1, 32'h300, 32'hA5A5_0300);
        drv(0, 1, 32'h400, 0, 1); fe("r4", 1, 0); id("r4", 0, 0, 0); chk("r4.addr", rom_addr_o, 32'h400);
        drv(0, 0, 32'h0, 0, 1);   fe("r5", 0, 0); id("r5", 0, 0, 0);
        drv(0, 0, 32'h0, 0, 1);   id("r6", 1, 32'h400, 32'hA5A5_0400);
        drv(0, 0, 32'h0, 0, 1);   id("r7", 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
